// File: rtl/rsa_pkg.sv
// Shared constants and types for the bit-serial RSA decryption core.
// Register-file command/status bit positions live here for the bus glue.
package rsa_pkg;

    localparam int WIDTH     = 8;
    localparam int MM_CYCLES = 9;
    localparam int BASE_MMS  = 11;

    localparam int CMD_START = 0;
    localparam int CMD_STOP  = 1;

    localparam int ST_DONE   = 0;
    localparam int ST_BUSY   = 1;
    localparam int ST_ERR    = 2;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE_X = 3'd1,
        S_PRE_A = 3'd2,
        S_SQR   = 3'd3,
        S_MUL   = 3'd4,
        S_POST  = 3'd5,
        S_DONE  = 3'd6
    } rsa_state_t;

endpackage

// File: rtl/rsa_mont_mul.sv
// Radix-2 Montgomery multiplier: result = a*b*2^-W mod n in MM_CYCLES cycles.
// done_o pulses the cycle after the final reduction, so a new start can chain in.
module rsa_mont_mul
    import rsa_pkg::*;
#(
    parameter int W = WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         start_i,
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] n_i,
    output logic [W-1:0] result_o,
    output logic         done_o
);

    localparam int SW = W + 2;
    localparam int CW = $clog2(MM_CYCLES);

    logic [SW-1:0] s_q, s_d;
    logic [W-1:0]  a_q, a_d, b_q, b_d, n_q, n_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          run_q, run_d, done_q, done_d;
    logic [SW-1:0] n_ext;

    function automatic logic [SW-1:0] mm_step(input logic [SW-1:0] s, input logic a_bit,
                                              input logic [W-1:0] b, input logic [W-1:0] n);
        logic [SW-1:0] t;
        t = s + (a_bit ? {{(SW-W){1'b0}}, b} : '0);
        if (t[0]) t = t + {{(SW-W){1'b0}}, n};
        return t >> 1;
    endfunction

    assign n_ext = {{(SW-W){1'b0}}, n_q};

    // The start edge already performs iteration j=0, keeping the total at MM_CYCLES.
    always_comb begin
        s_d    = s_q;
        a_d    = a_q;
        b_d    = b_q;
        n_d    = n_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        done_d = 1'b0;
        if (clr_i) begin
            run_d = 1'b0;
            cnt_d = '0;
        end else if (start_i) begin
            s_d   = mm_step('0, a_i[0], b_i, n_i);
            a_d   = a_i >> 1;
            b_d   = b_i;
            n_d   = n_i;
            cnt_d = CW'(1);
            run_d = 1'b1;
        end else if (run_q) begin
            if (cnt_q == CW'(MM_CYCLES - 1)) begin
                if (s_q >= n_ext) s_d = s_q - n_ext;
                run_d  = 1'b0;
                done_d = 1'b1;
                cnt_d  = '0;
            end else begin
                s_d   = mm_step(s_q, a_q[0], b_q, n_q);
                a_d   = a_q >> 1;
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            n_q    <= '0;
            cnt_q  <= '0;
            run_q  <= 1'b0;
            done_q <= 1'b0;
        end else begin
            s_q    <= s_d;
            a_q    <= a_d;
            b_q    <= b_d;
            n_q    <= n_d;
            cnt_q  <= cnt_d;
            run_q  <= run_d;
            done_q <= done_d;
        end
    end

    assign result_o = s_q[W-1:0];
    assign done_o   = done_q;

endmodule

// File: rtl/rsa_decrypt_core.sv
// Modular exponentiation plain = cipher^exp mod modulus, MSB-first square-and-multiply
// over back-to-back Montgomery products; software supplies R^2 mod N.
module rsa_decrypt_core
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start_i,
    input  logic             stop_i,
    input  logic [WIDTH-1:0] cipher_i,
    input  logic [WIDTH-1:0] exp_i,
    input  logic [WIDTH-1:0] mod_i,
    input  logic [WIDTH-1:0] mont_const_i,
    output logic [WIDTH-1:0] plain_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             error_o
);

    localparam int BW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    rsa_state_t       state_q, state_d;
    logic [WIDTH-1:0] c_q, c_d, e_q, e_d, n_q, n_d, k_q, k_d, x_q, x_d;
    logic [WIDTH-1:0] plain_q, plain_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic             kick_q, kick_d, even_q, even_d, done_q, done_d, err_q, err_d;
    logic             accept, last_bit;
    logic             mm_start, mm_done;
    logic [WIDTH-1:0] mm_a, mm_b, mm_res;

    rsa_mont_mul #(.W(WIDTH)) u_mm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_i    (stop_i),
        .start_i  (mm_start),
        .a_i      (mm_a),
        .b_i      (mm_b),
        .n_i      (n_q),
        .result_o (mm_res),
        .done_o   (mm_done)
    );

    always_comb begin
        state_d  = state_q;
        c_d      = c_q;
        e_d      = e_q;
        n_d      = n_q;
        k_d      = k_q;
        x_d      = x_q;
        plain_d  = plain_q;
        bit_d    = bit_q;
        kick_d   = kick_q;
        even_d   = even_q;
        done_d   = done_q;
        err_d    = err_q;
        mm_start = 1'b0;
        mm_a     = mm_res;
        mm_b     = mm_res;
        last_bit = (bit_q == '0);
        accept   = start_i && !even_q && (state_q == S_IDLE || state_q == S_DONE);

        if (stop_i) begin
            state_d = S_IDLE;
            kick_d  = 1'b0;
            even_d  = 1'b0;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else if (accept) begin
            c_d    = cipher_i;
            e_d    = exp_i;
            n_d    = mod_i;
            k_d    = mont_const_i;
            done_d = 1'b0;
            err_d  = 1'b0;
            if (mod_i[0]) begin
                state_d = S_PRE_X;
                kick_d  = 1'b1;
            end else begin
                // Even modulus is flagged one cycle later without ever going busy.
                even_d  = 1'b1;
                state_d = S_IDLE;
            end
        end else if (even_q) begin
            even_d  = 1'b0;
            state_d = S_DONE;
            done_d  = 1'b1;
            err_d   = 1'b1;
        end else if (kick_q) begin
            kick_d   = 1'b0;
            mm_start = 1'b1;
            mm_a     = c_q;
            mm_b     = k_q;
        end else if (mm_done) begin
            case (state_q)
                S_PRE_X: begin
                    x_d      = mm_res;
                    state_d  = S_PRE_A;
                    mm_start = 1'b1;
                    mm_a     = ONE;
                    mm_b     = k_q;
                end
                S_PRE_A: begin
                    state_d  = S_SQR;
                    bit_d    = BW'(WIDTH - 1);
                    mm_start = 1'b1;
                end
                S_SQR: begin
                    mm_start = 1'b1;
                    if (e_q[bit_q]) begin
                        state_d = S_MUL;
                        mm_b    = x_q;
                    end else if (last_bit) begin
                        state_d = S_POST;
                        mm_b    = ONE;
                    end else begin
                        bit_d   = bit_q - BW'(1);
                    end
                end
                S_MUL: begin
                    mm_start = 1'b1;
                    if (last_bit) begin
                        state_d = S_POST;
                        mm_b    = ONE;
                    end else begin
                        state_d = S_SQR;
                        bit_d   = bit_q - BW'(1);
                    end
                end
                S_POST: begin
                    plain_d = mm_res;
                    state_d = S_DONE;
                    done_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            e_q     <= '0;
            n_q     <= '0;
            k_q     <= '0;
            x_q     <= '0;
            plain_q <= '0;
            bit_q   <= '0;
            kick_q  <= 1'b0;
            even_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            c_q     <= c_d;
            e_q     <= e_d;
            n_q     <= n_d;
            k_q     <= k_d;
            x_q     <= x_d;
            plain_q <= plain_d;
            bit_q   <= bit_d;
            kick_q  <= kick_d;
            even_q  <= even_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign plain_o = plain_q;
    assign busy_o  = (state_q != S_IDLE) && (state_q != S_DONE);
    assign done_o  = done_q;
    assign error_o = err_q;

endmodule

// File: tb/tb_rsa_decrypt_core.sv
// Bench for rsa_decrypt_core: directed cases plus random odd moduli, checked
// against a plain square-and-multiply reference and a cycle-count model.
module tb_rsa_decrypt_core;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start_i = 1'b0;
    logic       stop_i = 1'b0;
    logic [7:0] cipher_i = '0, exp_i = '0, mod_i = '0, mont_const_i = '0;
    logic [7:0] plain_o;
    logic       busy_o, done_o, error_o;

    int n_chk = 0;
    int n_pass = 0;

    rsa_decrypt_core #(.WIDTH(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .cipher_i     (cipher_i),
        .exp_i        (exp_i),
        .mod_i        (mod_i),
        .mont_const_i (mont_const_i),
        .plain_o      (plain_o),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .error_o      (error_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    function automatic int ref_modexp(input int c, input int e, input int n);
        longint r, b;
        r = 1 % n;
        b = c % n;
        for (int i = 7; i >= 0; i--) begin
            r = (r * r) % n;
            if (((e >> i) & 1) == 1) r = (r * b) % n;
        end
        return int'(r);
    endfunction

    function automatic int ref_lat(input int e);
        return 9 * (11 + $countones(e[7:0])) + 1;
    endfunction

    // Leaves the caller at the falling edge right after the sampling edge.
    task automatic kick(input int c, input int e, input int n, input int k);
        @(negedge clk);
        cipher_i = 8'(c); exp_i = 8'(e); mod_i = 8'(n); mont_const_i = 8'(k);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done_o && lat < 400) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic pulse_stop();
        @(negedge clk);
        stop_i = 1'b1;
        @(negedge clk);
        stop_i = 1'b0;
    endtask

    task automatic run_chk(input string tag, input int c, input int e, input int n);
        int lat;
        kick(c, e, n, 65536 % n);
        chk({tag, "_busy"}, busy_o, 1);
        chk({tag, "_done_clr"}, done_o, 0);
        wait_done(lat);
        chk({tag, "_lat"}, lat, ref_lat(e));
        chk({tag, "_plain"}, plain_o, ref_modexp(c, e, n));
        chk({tag, "_err"}, error_o, 0);
        chk({tag, "_idle"}, busy_o, 0);
    endtask

    initial begin
        int lat;
        int c, e, n;

        repeat (3) @(negedge clk);
        chk("rst_plain", plain_o, 0);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_err", error_o, 0);
        rst_n = 1'b1;

        run_chk("t187", 11, 23, 187);
        chk("t187_const", plain_o, 88);
        run_chk("t33", 31, 7, 33);
        chk("t33_const", plain_o, 4);
        run_chk("t200", 200, 1, 187);
        chk("t200_const", plain_o, 13);

        // Abort mid-run: flags clear, plain text holds the previous result.
        kick(11, 23, 187, 86);
        repeat (48) @(negedge clk);
        pulse_stop();
        chk("stop_busy", busy_o, 0);
        chk("stop_done", done_o, 0);
        chk("stop_err", error_o, 0);
        chk("stop_plain", plain_o, 13);
        run_chk("restart", 11, 23, 187);

        // Even modulus: one-cycle error completion, never busy.
        kick(5, 3, 186, 0);
        chk("even_busy0", busy_o, 0);
        chk("even_done0", done_o, 0);
        @(negedge clk);
        chk("even_done", done_o, 1);
        chk("even_err", error_o, 1);
        chk("even_busy1", busy_o, 0);
        chk("even_plain", plain_o, 88);

        run_chk("e0", 11, 0, 187);
        chk("e0_const", plain_o, 1);
        run_chk("n1", 11, 8'h17, 1);

        // A second start while busy must be ignored, including the new cipher.
        kick(11, 23, 187, 86);
        repeat (19) @(negedge clk);
        cipher_i = 8'd99;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        wait_done(lat);
        chk("dbl_lat", 20 + lat, 136);
        chk("dbl_plain", plain_o, 88);

        pulse_stop();
        @(negedge clk);
        start_i = 1'b1; stop_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; stop_i = 1'b0;
        chk("ss_busy", busy_o, 0);
        @(negedge clk);
        chk("ss_busy2", busy_o, 0);
        chk("ss_done", done_o, 0);

        for (int i = 0; i < 16; i++) begin
            n = 2 * int'($urandom_range(0, 127)) + 1;
            c = int'($urandom_range(0, 255));
            e = int'($urandom_range(0, 255));
            run_chk($sformatf("rnd%0d", i), c, e, n);
        end

        kick(11, 23, 187, 86);
        repeat (69) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("mrst_plain", plain_o, 0);
        chk("mrst_busy", busy_o, 0);
        chk("mrst_done", done_o, 0);
        chk("mrst_err", error_o, 0);
        rst_n = 1'b1;
        @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
